wb_stage_buf: RTL and testbench

Parametrised writeback stage with an integrated MEM/WB buffer. It accepts MEM-stage results through a valid/ready handshake and aligns and extends load data by load type and byte offset. It selects between load data and ALU result, then holds up to two pending register-file writes in a skid buffer drained by a write-port handshake. It sits between the MEM stage and the register-file write port, and provides an ID-stage bypass query into its pending writes.

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_load_align.sv | 51 +++++
 rtl/wb_stage_buf.sv | 136 +++++++++++++
 tb/tb_wb_stage_buf.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_pkg
// Brief   : Shared load-type codes, ctrl bit indices and buffer state encoding.
// Revision: 1.0
// ============================================================================
package wb_pkg;

  localparam logic [2:0] LD_FULL = 3'b000;
  localparam logic [2:0] LD_H    = 3'b001;
  localparam logic [2:0] LD_HU   = 3'b010;
  localparam logic [2:0] LD_B    = 3'b011;
  localparam logic [2:0] LD_BU   = 3'b100;
  localparam logic [2:0] LD_W    = 3'b101;
  localparam logic [2:0] LD_WU   = 3'b110;

  localparam int CTRL_REG_WRITE  = 1;
  localparam int CTRL_MEM_TO_REG = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/wb_load_align.sv
`default_nettype none
// ============================================================================
// Module  : wb_load_align
// Brief   : Little-endian load extraction and sign/zero extension.
// Revision: 1.0
// ============================================================================
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic [2:0]        i_ld_type,
  input  logic [OFF_W-1:0]  i_byte_off,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_word_ext;

  assign w_byte = 8'(i_mem_data >> {i_byte_off, 3'b000});
  assign w_half = 16'(i_mem_data >> {i_byte_off[OFF_W-1:1], 4'b0000});

  generate
    if (DATA_W == 64) begin : g_word
      logic [31:0] w_word;
      assign w_word     = 32'(i_mem_data >> {i_byte_off[OFF_W-1:2], 5'b00000});
      assign w_word_ext = (i_ld_type == LD_W) ? {{(DATA_W-32){w_word[31]}}, w_word}
                                              : {{(DATA_W-32){1'b0}}, w_word};
    end else begin : g_noword
      // A 32-bit word load is the whole datapath word.
      assign w_word_ext = i_mem_data;
    end
  endgenerate

  always_comb begin
    o_data = i_mem_data;
    case (i_ld_type)
      LD_H:        o_data = {{(DATA_W-16){w_half[15]}}, w_half};
      LD_HU:       o_data = {{(DATA_W-16){1'b0}}, w_half};
      LD_B:        o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LD_BU:       o_data = {{(DATA_W-8){1'b0}}, w_byte};
      LD_W, LD_WU: o_data = w_word_ext;
      default:     o_data = i_mem_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage_buf.sv
`default_nettype none
// ============================================================================
// Module  : wb_stage_buf
// Brief   : Writeback stage with 2-entry MEM/WB skid buffer and ID bypass query.
//           Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
// Revision: 1.0
// ============================================================================
module wb_stage_buf
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OFF_W      = $clog2(DATA_W/8)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_ctrl,
  input  logic [2:0]            in_ld_type,
  input  logic [OFF_W-1:0]      in_byte_off,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic                  flush,
  output logic                  rf_we,
  input  logic                  rf_ready,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  input  logic [REG_ADDR_W-1:0] q_addr,
  output logic                  q_hit,
  output logic [DATA_W-1:0]     q_data
`ifdef WB_RETIRE_CNT_EN
  ,output logic [31:0]          retire_cnt
`endif
);

  wb_state_e             r_state;
  wb_state_e             w_state_nxt;
  logic                  r_in_ready;
  logic [REG_ADDR_W-1:0] r_addr0, r_addr1;
  logic [DATA_W-1:0]     r_data0, r_data1;

  logic [DATA_W-1:0]     w_ld_data;
  logic [DATA_W-1:0]     w_wdata;
  logic                  w_accept, w_push, w_pop;
  logic                  w_hit0, w_hit1, w_q_nz;

  wb_load_align #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_align (
    .i_mem_data (in_mem_data),
    .i_ld_type  (in_ld_type),
    .i_byte_off (in_byte_off),
    .o_data     (w_ld_data)
  );

  assign w_wdata  = in_ctrl[CTRL_MEM_TO_REG] ? w_ld_data : in_alu_result;
  assign w_accept = in_valid & r_in_ready & ~flush;
  assign w_push   = w_accept & in_ctrl[CTRL_REG_WRITE] & (in_rd != '0);
  assign w_pop    = rf_we & rf_ready;

  assign in_ready = r_in_ready;
  assign rf_we    = (r_state != ST_EMPTY);
  assign rf_waddr = r_addr0;
  assign rf_wdata = r_data0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
      ST_ONE: begin
        if (w_push && !w_pop)      w_state_nxt = ST_FULL;
        else if (w_pop && !w_push) w_state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (w_pop) w_state_nxt = ST_ONE;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Entry 0 is always the head; entry 1 only holds data in FULL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_addr0    <= '0;
      r_addr1    <= '0;
      r_data0    <= '0;
      r_data1    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_addr0 <= in_rd;
            r_data0 <= w_wdata;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            r_addr0 <= in_rd;
            r_data0 <= w_wdata;
          end else if (w_push) begin
            r_addr1 <= in_rd;
            r_data1 <= w_wdata;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            r_addr0 <= r_addr1;
            r_data0 <= r_data1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_q_nz = (q_addr != '0);
  assign w_hit0 = (r_state != ST_EMPTY) && (r_addr0 == q_addr);
  assign w_hit1 = (r_state == ST_FULL) && (r_addr1 == q_addr);
  assign q_hit  = w_q_nz & (w_hit0 | w_hit1);
  assign q_data = !w_q_nz ? '0 : (w_hit1 ? r_data1 : (w_hit0 ? r_data0 : '0));

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)        r_retire_cnt <= '0;
    else if (w_accept) r_retire_cnt <= r_retire_cnt + 32'd1;
  end

  assign retire_cnt = r_retire_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_buf.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_stage_buf
// Brief   : Scoreboard bench for wb_stage_buf (32-bit and 64-bit instances).
// Revision: 1.0
// ============================================================================
module tb_wb_stage_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0;
  logic [1:0]  in_ctrl = '0;
  logic [2:0]  in_ld_type = '0;
  logic [1:0]  in_byte_off = '0;
  logic [4:0]  in_rd = '0, rf_waddr, q_addr = '0;
  logic [31:0] in_mem_data = '0, in_alu_result = '0, rf_wdata, q_data;
  logic        rf_we, rf_ready = 1'b0, q_hit;

  logic        d64_in_valid = 1'b0, d64_in_ready, d64_rf_we, d64_q_hit;
  logic [1:0]  d64_in_ctrl = '0;
  logic [2:0]  d64_ld_type = '0;
  logic [2:0]  d64_byte_off = '0;
  logic [4:0]  d64_rd = '0, d64_rf_waddr;
  logic [63:0] d64_mem = '0, d64_alu = '0, d64_rf_wdata, d64_q_data;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt, d64_retire_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_stage_buf #(.DATA_W(32), .REG_ADDR_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_ld_type(in_ld_type), .in_byte_off(in_byte_off),
    .in_rd(in_rd), .in_mem_data(in_mem_data), .in_alu_result(in_alu_result),
    .flush(flush), .rf_we(rf_we), .rf_ready(rf_ready), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data)
`ifdef WB_RETIRE_CNT_EN
    ,.retire_cnt(retire_cnt)
`endif
  );

  wb_stage_buf #(.DATA_W(64), .REG_ADDR_W(5)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(d64_in_valid), .in_ready(d64_in_ready),
    .in_ctrl(d64_in_ctrl), .in_ld_type(d64_ld_type), .in_byte_off(d64_byte_off),
    .in_rd(d64_rd), .in_mem_data(d64_mem), .in_alu_result(d64_alu),
    .flush(1'b0), .rf_we(d64_rf_we), .rf_ready(1'b1), .rf_waddr(d64_rf_waddr),
    .rf_wdata(d64_rf_wdata), .q_addr(5'd0), .q_hit(d64_q_hit), .q_data(d64_q_data)
`ifdef WB_RETIRE_CNT_EN
    ,.retire_cnt(d64_retire_cnt)
`endif
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference load extraction from byte-lane arithmetic, for width w (32/64).
  function automatic logic [63:0] ref_load(input int w, input logic [63:0] mem_in,
                                           input logic [2:0] t, input int off);
    logic [63:0] mem, v, m;
    int sz, idx;
    bit sgn;
    mem = (w == 32) ? (mem_in & 64'hFFFF_FFFF) : mem_in;
    sz = w; idx = 0; sgn = 0;
    case (t)
      3'd1: begin sz = 16; idx = off & ~1; sgn = 1; end
      3'd2: begin sz = 16; idx = off & ~1; sgn = 0; end
      3'd3: begin sz = 8;  idx = off;      sgn = 1; end
      3'd4: begin sz = 8;  idx = off;      sgn = 0; end
      3'd5, 3'd6: if (w == 64) begin sz = 32; idx = off & ~3; sgn = (t == 3'd5); end
      default: ;
    endcase
    m = (sz == 64) ? '1 : ((64'd1 << sz) - 64'd1);
    v = (mem >> (idx * 8)) & m;
    if (sgn && v[sz-1]) v = v | ~m;
    if (w == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  // Scoreboard model for the 32-bit instance.
  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        m_q[$];
  bit          m_ready = 1;
  bit          m_live = 0;
  bit          m_fresh = 0;
  int unsigned m_cnt = 0;

  always @(negedge clk) begin
    bit          acc, pop, ehit;
    logic [31:0] edata, ewd;
    if (m_live) begin
      check("in_ready", in_ready, m_ready);
      check("rf_we", rf_we, m_q.size() > 0);
      if (m_q.size() > 0) begin
        check("rf_waddr", rf_waddr, m_q[0].a);
        check("rf_wdata", rf_wdata, m_q[0].d);
      end else if (m_fresh) begin
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
      end
      ehit = 0; edata = 0;
      if (q_addr != 0)
        foreach (m_q[i]) if (m_q[i].a == q_addr) begin ehit = 1; edata = m_q[i].d; end
      check("q_hit", q_hit, ehit);
      check("q_data", q_data, edata);
`ifdef WB_RETIRE_CNT_EN
      check("retire_cnt", retire_cnt, m_cnt);
`endif
    end
    if (!rst_n) begin
      m_q.delete();
      m_ready = 1; m_live = 1; m_fresh = 1; m_cnt = 0;
    end else if (m_live) begin
      acc = in_valid && m_ready && !flush;
      pop = (m_q.size() > 0) && rf_ready;
      ewd = in_ctrl[0] ? 32'(ref_load(32, {32'd0, in_mem_data}, in_ld_type, int'(in_byte_off)))
                       : in_alu_result;
      if (pop) void'(m_q.pop_front());
      if (acc) m_cnt++;
      if (acc && in_ctrl[1] && in_rd != 0) begin
        m_q.push_back('{a: in_rd, d: ewd});
        m_fresh = 0;
      end
      m_ready = (m_q.size() != 2);
    end
  end

  task automatic beat(input logic [1:0] c, input logic [2:0] t, input logic [1:0] off,
                      input logic [4:0] rd, input logic [31:0] mem, input logic [31:0] alu);
    in_valid = 1; in_ctrl = c; in_ld_type = t; in_byte_off = off;
    in_rd = rd; in_mem_data = mem; in_alu_result = alu;
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
  endtask

  task automatic beat64(input logic [2:0] t, input logic [2:0] off, input logic [63:0] mem,
                        input logic [63:0] exp, input string nm);
    d64_in_valid = 1; d64_in_ctrl = 2'b11; d64_ld_type = t; d64_byte_off = off;
    d64_rd = 5'd7; d64_mem = mem; d64_alu = {$urandom, $urandom};
    @(posedge clk); #1;
    d64_in_valid = 0;
    @(negedge clk);
    check({nm, "_we"}, d64_rf_we, 1);
    check(nm, d64_rf_wdata, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    q_addr = 5'd5;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    rf_ready = 1;

    // Directed loads.
    beat(2'b11, 3'b011, 2'd3, 5'd4, 32'h80FF_1234, 32'h1111_1111);
    @(negedge clk);
    check("lb_we", rf_we, 1); check("lb_addr", rf_waddr, 4); check("lb_data", rf_wdata, 32'hFFFF_FF80);
    @(posedge clk); #1;
    beat(2'b11, 3'b100, 2'd3, 5'd4, 32'h80FF_1234, 32'h1111_1111);
    @(negedge clk); check("lbu_data", rf_wdata, 32'h0000_0080);
    @(posedge clk); #1;
    beat(2'b11, 3'b001, 2'd2, 5'd4, 32'h80FF_1234, 32'h1111_1111);
    @(negedge clk); check("lh_data", rf_wdata, 32'hFFFF_80FF);
    @(posedge clk); #1;

    // Fill to FULL with the write port stalled, then drain.
    rf_ready = 0;
    beat(2'b10, 3'b000, 2'd0, 5'd1, 32'h0, 32'hAAAA_0001);
    beat(2'b10, 3'b000, 2'd0, 5'd2, 32'h0, 32'hBBBB_0002);
    q_addr = 5'd2;
    @(negedge clk);
    check("full_ready", in_ready, 0); check("full_qhit", q_hit, 1);
    check("full_qdata", q_data, 32'hBBBB_0002);
    @(posedge clk); #1 rf_ready = 1;
    @(negedge clk); check("drain1_addr", rf_waddr, 1);
    @(posedge clk); #1;
    @(negedge clk); check("drain2_addr", rf_waddr, 2); check("drain2_ready", in_ready, 1);
    @(posedge clk); #1;

    // Beats that are consumed but not stored.
    beat(2'b10, 3'b000, 2'd0, 5'd0, 32'h0, 32'h1234_5678);
    @(negedge clk); check("rd0_we", rf_we, 0);
    @(posedge clk); #1;
    beat(2'b01, 3'b000, 2'd0, 5'd3, 32'h5, 32'h6);
    @(negedge clk); check("nowr_we", rf_we, 0);
    @(posedge clk); #1;

    // Flush with one entry buffered.
    rf_ready = 0;
    beat(2'b10, 3'b000, 2'd0, 5'd3, 32'h0, 32'hCCCC_0003);
    flush = 1;
    beat(2'b10, 3'b000, 2'd0, 5'd5, 32'h0, 32'hDDDD_0005);
    q_addr = 5'd5;
    @(negedge clk); check("flush_addr", rf_waddr, 3); check("flush_qhit", q_hit, 0);
    @(posedge clk); #1 rf_ready = 1;
    @(posedge clk); #1;

    // Reset in the middle of a write handshake.
    rf_ready = 0;
    beat(2'b10, 3'b000, 2'd0, 5'd9, 32'h0, 32'h9999_0009);
    rf_ready = 1; rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); check("rst_we", rf_we, 0); check("rst_ready", in_ready, 1);
    @(posedge clk); #1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid      = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 9) == 0);
      in_ctrl       = 2'($urandom);
      in_ld_type    = 3'($urandom);
      in_byte_off   = 2'($urandom);
      in_rd         = 5'($urandom_range(0, 7));
      in_mem_data   = $urandom;
      in_alu_result = $urandom;
      rf_ready      = ($urandom_range(0, 9) < 6);
      q_addr        = 5'($urandom_range(0, 7));
      rst_n         = ($urandom_range(0, 199) != 0);
      @(posedge clk); #1;
    end
    in_valid = 0; flush = 0; rst_n = 1; rf_ready = 1;
    repeat (4) @(posedge clk);
    #1;

    // 64-bit datapath.
    beat64(3'b101, 3'd4, 64'h8000_0001_0000_0002, 64'hFFFF_FFFF_8000_0001, "lw64");
    beat64(3'b110, 3'd4, 64'h8000_0001_0000_0002, 64'h0000_0000_8000_0001, "lwu64");
    for (int i = 0; i < 100; i++) begin
      logic [63:0] mem;
      logic [2:0]  t, off;
      mem = {$urandom, $urandom};
      t   = 3'($urandom);
      off = 3'($urandom);
      beat64(t, off, mem, ref_load(64, mem, t, int'(off)), "rnd64");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
